// File: rtl/load_ext_pkg.sv
// Shared types for the load-data extension stage: access size encoding,
// buffer entry layout, skid-buffer state encoding and a size helper.
package load_ext_pkg;

  // Access size as presented on in_size.
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Entry fields are sized for the widest supported configuration; each
  // instance uses the low OUT_W / TAG_W bits.
  localparam int ENTRY_DATA_W = 128;
  localparam int ENTRY_TAG_W  = 16;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_TAG_W-1:0]  tag;
    logic                    misalign;
  } entry_t;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Number of bytes covered by an access of the given size.
  function automatic logic [3:0] size_bytes(input size_e size);
    logic [3:0] nbytes;
    case (size)
      SZ_BYTE:  nbytes = 4'd1;
      SZ_HALF:  nbytes = 4'd2;
      SZ_WORD:  nbytes = 4'd4;
      SZ_DWORD: nbytes = 4'd8;
      default:  nbytes = 4'd1;
    endcase
    return nbytes;
  endfunction

endpackage

// File: rtl/load_extend_unit_lane_extend.sv
// Combinational lane select, sign/zero extension and alignment check for
// one memory word. Misaligned or oversized accesses yield zero data.
module lane_extend
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32
) (
  input  logic [DATA_W-1:0]           data,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  size_e                       size,
  input  logic                        sign,
  output logic [OUT_W-1:0]            result,
  output logic                        misalign
);

  logic [3:0]        nbytes_s;
  logic [6:0]        width_bits_s;
  logic [DATA_W-1:0] shifted_s;
  logic [OUT_W-1:0]  wide_s;
  logic [OUT_W-1:0]  mask_s;
  logic [OUT_W-1:0]  top_s;
  logic              fill_s;
  logic              unaligned_s;
  logic              illegal_s;

  // Shift the addressed lane down, mask it to the field width and fill the
  // upper bits; the mask trick covers the full-width case without any
  // zero-width replication.
  always_comb begin
    nbytes_s     = size_bytes(size);
    width_bits_s = {nbytes_s, 3'b000};
    shifted_s    = data >> {offset, 3'b000};
    wide_s       = OUT_W'(shifted_s);
    mask_s       = (OUT_W'(1'b1) << width_bits_s) - OUT_W'(1'b1);
    top_s        = wide_s >> (width_bits_s - 7'd1);
    fill_s       = top_s[0] & sign;
    unaligned_s  = (4'(offset) & (nbytes_s - 4'd1)) != 4'd0;
    illegal_s    = 32'(nbytes_s) > 32'(DATA_W / 8);
    misalign     = unaligned_s | illegal_s;
    if (misalign) begin
      result = '0;
    end else begin
      result = (wide_s & mask_s) | ({OUT_W{fill_s}} & ~mask_s);
    end
  end

endmodule

// File: rtl/load_extend_unit.sv
// Load-data extension stage: extends the incoming memory word at accept
// time and holds results in a 2-entry skid buffer so memory and write-back
// sides can stall independently.
module load_extend_unit
  import load_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32,
  parameter int TAG_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(DATA_W/8)-1:0] in_offset,
  input  logic [1:0]                  in_size,
  input  logic                        in_sign,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_misalign
);

  logic [OUT_W-1:0] ext_s;
  logic             mis_s;
  buf_state_e       state_r;
  buf_state_e       state_next_s;
  logic             in_ready_r;
  logic             head_r;
  logic             tail_r;
  entry_t           mem_r [2];
  logic             accept_s;
  logic             emit_s;

  lane_extend #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_lane (
    .data     (in_data),
    .offset   (in_offset),
    .size     (size_e'(in_size)),
    .sign     (in_sign),
    .result   (ext_s),
    .misalign (mis_s)
  );

  assign in_ready     = in_ready_r;
  assign out_valid    = (state_r != ST_EMPTY);
  assign accept_s     = in_valid & in_ready_r;
  assign emit_s       = out_valid & out_ready;
  assign out_data     = mem_r[head_r].data[OUT_W-1:0];
  assign out_tag      = mem_r[head_r].tag[TAG_W-1:0];
  assign out_misalign = mem_r[head_r].misalign;

  // Occupancy transitions; flush overrides any accept or emit.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) state_next_s = ST_ONE;
          else          state_next_s = ST_EMPTY;
        end
        ST_ONE: begin
          if (accept_s && !emit_s)      state_next_s = ST_FULL;
          else if (!accept_s && emit_s) state_next_s = ST_EMPTY;
          else                          state_next_s = ST_ONE;
        end
        ST_FULL: begin
          if (emit_s) state_next_s = ST_ONE;
          else        state_next_s = ST_FULL;
        end
        default: state_next_s = ST_EMPTY;
      endcase
    end
  end

  // State register and registered in_ready, which looks only at the next
  // occupancy so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s != ST_FULL);
    end
  end

  // Entry storage and head/tail pointers; reset clears entries so the
  // outputs read back as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r <= 1'b0;
      tail_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      head_r <= 1'b0;
      tail_r <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[tail_r].data     <= ENTRY_DATA_W'(ext_s);
        mem_r[tail_r].tag      <= ENTRY_TAG_W'(in_tag);
        mem_r[tail_r].misalign <= mis_s;
        tail_r                 <= ~tail_r;
      end
      if (emit_s) begin
        head_r <= ~head_r;
      end
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed self-checking bench for load_extend_unit: a 32-bit instance for
// extension, handshake, flush and reset scenarios and a 64-bit instance for
// doubleword lanes.
module tb_load_extend_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_offset;
  logic [1:0]  in_size;
  logic        in_sign;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_misalign;

  logic        w_flush;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [63:0] w_in_data;
  logic [2:0]  w_in_offset;
  logic [1:0]  w_in_size;
  logic        w_in_sign;
  logic [4:0]  w_in_tag;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;
  logic        w_out_misalign;

  int checks;
  int failures;

  load_extend_unit #(.DATA_W(32), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_size(in_size), .in_sign(in_sign), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_misalign(out_misalign)
  );

  load_extend_unit #(.DATA_W(64), .OUT_W(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_offset(w_in_offset), .in_size(w_in_size), .in_sign(w_in_sign), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_misalign(w_out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                         input logic sg, input logic [4:0] tg);
    in_data   = d;
    in_offset = off;
    in_size   = sz;
    in_sign   = sg;
    in_tag    = tg;
    in_valid  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++;
    if (out_data !== 32'h0 || out_tag !== 5'd0 || out_misalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs data=%h tag=%0d mis=%0b want 0/0/0", out_data, out_tag, out_misalign);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_extend32();
    logic [31:0] vd  [12];
    logic [1:0]  vo  [12];
    logic [1:0]  vs  [12];
    logic        vg  [12];
    logic [31:0] ve  [12];
    logic        vm  [12];
    vd[0]  = 32'h8000_80F0; vo[0]  = 2'd0; vs[0]  = 2'd0; vg[0]  = 1'b1; ve[0]  = 32'hFFFF_FFF0; vm[0]  = 1'b0;
    vd[1]  = 32'h8000_80F0; vo[1]  = 2'd0; vs[1]  = 2'd0; vg[1]  = 1'b0; ve[1]  = 32'h0000_00F0; vm[1]  = 1'b0;
    vd[2]  = 32'h8001_1234; vo[2]  = 2'd2; vs[2]  = 2'd1; vg[2]  = 1'b1; ve[2]  = 32'hFFFF_8001; vm[2]  = 1'b0;
    vd[3]  = 32'h8001_1234; vo[3]  = 2'd1; vs[3]  = 2'd1; vg[3]  = 1'b1; ve[3]  = 32'h0000_0000; vm[3]  = 1'b1;
    vd[4]  = 32'h8001_1234; vo[4]  = 2'd0; vs[4]  = 2'd3; vg[4]  = 1'b0; ve[4]  = 32'h0000_0000; vm[4]  = 1'b1;
    vd[5]  = 32'h8001_1234; vo[5]  = 2'd0; vs[5]  = 2'd2; vg[5]  = 1'b1; ve[5]  = 32'h8001_1234; vm[5]  = 1'b0;
    vd[6]  = 32'h8001_1234; vo[6]  = 2'd3; vs[6]  = 2'd0; vg[6]  = 1'b1; ve[6]  = 32'hFFFF_FF80; vm[6]  = 1'b0;
    vd[7]  = 32'h8001_1234; vo[7]  = 2'd3; vs[7]  = 2'd0; vg[7]  = 1'b0; ve[7]  = 32'h0000_0080; vm[7]  = 1'b0;
    vd[8]  = 32'h8001_1234; vo[8]  = 2'd0; vs[8]  = 2'd1; vg[8]  = 1'b1; ve[8]  = 32'h0000_1234; vm[8]  = 1'b0;
    vd[9]  = 32'h8001_1234; vo[9]  = 2'd2; vs[9]  = 2'd2; vg[9]  = 1'b0; ve[9]  = 32'h0000_0000; vm[9]  = 1'b1;
    vd[10] = 32'h8000_80F0; vo[10] = 2'd1; vs[10] = 2'd0; vg[10] = 1'b1; ve[10] = 32'hFFFF_FF80; vm[10] = 1'b0;
    vd[11] = 32'h8000_80F0; vo[11] = 2'd2; vs[11] = 2'd1; vg[11] = 1'b0; ve[11] = 32'h0000_8000; vm[11] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive32(vd[i], vo[i], vs[i], vg[i], 5'(i));
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ve[i] || out_misalign !== vm[i] || out_tag !== 5'(i)) begin
        failures++;
        $display("FAIL extend32[%0d] got v=%0b d=%h m=%0b t=%0d want v=1 d=%h m=%0b t=%0d",
                 i, out_valid, out_data, out_misalign, out_tag, ve[i], vm[i], i);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL extend32_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_extend64();
    logic [63:0] vd [5];
    logic [2:0]  vo [5];
    logic [1:0]  vs [5];
    logic        vg [5];
    logic [63:0] ve [5];
    logic        vm [5];
    vd[0] = 64'h8000_0000_0000_0001; vo[0] = 3'd0; vs[0] = 2'd3; vg[0] = 1'b1; ve[0] = 64'h8000_0000_0000_0001; vm[0] = 1'b0;
    vd[1] = 64'h8000_0000_0000_0001; vo[1] = 3'd4; vs[1] = 2'd2; vg[1] = 1'b1; ve[1] = 64'hFFFF_FFFF_8000_0000; vm[1] = 1'b0;
    vd[2] = 64'h8000_0000_0000_0001; vo[2] = 3'd4; vs[2] = 2'd3; vg[2] = 1'b1; ve[2] = 64'h0;                   vm[2] = 1'b1;
    vd[3] = 64'h8000_0000_0000_0001; vo[3] = 3'd7; vs[3] = 2'd0; vg[3] = 1'b0; ve[3] = 64'h0000_0000_0000_0080; vm[3] = 1'b0;
    vd[4] = 64'h8000_0000_0000_0001; vo[4] = 3'd6; vs[4] = 2'd1; vg[4] = 1'b1; ve[4] = 64'hFFFF_FFFF_FFFF_8000; vm[4] = 1'b0;
    w_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_in_data   = vd[i];
      w_in_offset = vo[i];
      w_in_size   = vs[i];
      w_in_sign   = vg[i];
      w_in_tag    = 5'(i + 16);
      w_in_valid  = 1'b1;
      tick();
      w_in_valid = 1'b0;
      checks++;
      if (w_out_valid !== 1'b1 || w_out_data !== ve[i] || w_out_misalign !== vm[i] || w_out_tag !== 5'(i + 16)) begin
        failures++;
        $display("FAIL extend64[%0d] got v=%0b d=%h m=%0b t=%0d want v=1 d=%h m=%0b t=%0d",
                 i, w_out_valid, w_out_data, w_out_misalign, w_out_tag, ve[i], vm[i], i + 16);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive32(32'h0000_0011, 2'd0, 2'd0, 1'b0, 5'd1);
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_one got=%0b want=1", in_ready); end
    drive32(32'h0000_0022, 2'd0, 2'd0, 1'b0, 5'd2);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd1) begin
      failures++;
      $display("FAIL b2b_full got ready=%0b tag=%0d want ready=0 tag=1", in_ready, out_tag);
    end
    drive32(32'h0000_0033, 2'd0, 2'd0, 1'b0, 5'd3);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11 || out_tag !== 5'd1) begin
      failures++;
      $display("FAIL b2b_hold got r=%0b v=%0b d=%h t=%0d want r=0 v=1 d=11 t=1", in_ready, out_valid, out_data, out_tag);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 32'h22 || out_tag !== 5'd2 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got d=%h t=%0d r=%0b want d=22 t=2 r=1", out_data, out_tag, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h33 || out_tag !== 5'd3) begin
      failures++;
      $display("FAIL b2b_third got v=%0b d=%h t=%0d want v=1 d=33 t=3", out_valid, out_data, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive32(32'h0000_0044, 2'd0, 2'd0, 1'b0, 5'd1);
    tick();
    drive32(32'h0000_0055, 2'd0, 2'd0, 1'b0, 5'd2);
    tick();
    drive32(32'h0000_0066, 2'd0, 2'd0, 1'b0, 5'd3);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_after got=%0b want=0", out_valid); end
    out_ready = 1'b0;
    drive32(32'h0000_0070, 2'd0, 2'd0, 1'b0, 5'd4);
    tick();
    drive32(32'h0000_0077, 2'd0, 2'd0, 1'b0, 5'd5);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one got=%0b want=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_after got=%0b want=0", out_valid); end
    drive32(32'h0000_0099, 2'd0, 2'd0, 1'b0, 5'd6);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h99 || out_tag !== 5'd6) begin
      failures++;
      $display("FAIL flush_resume got v=%0b d=%h t=%0d want v=1 d=99 t=6", out_valid, out_data, out_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive32(32'h8001_1234, 2'd1, 2'd1, 1'b1, 5'd7);
    tick();
    drive32(32'h8001_1234, 2'd0, 2'd2, 1'b0, 5'd8);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_tag !== 5'd7 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pre got v=%0b m=%0b t=%0d r=%0b want v=1 m=1 t=7 r=0",
               out_valid, out_misalign, out_tag, in_ready);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0 || out_misalign !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_held got v=%0b d=%h t=%0d m=%0b r=%0b want all 0",
               out_valid, out_data, out_tag, out_misalign, in_ready);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release got r=%0b v=%0b want r=1 v=0", in_ready, out_valid);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    in_offset   = 2'd0;
    in_size     = 2'd0;
    in_sign     = 1'b0;
    in_tag      = 5'd0;
    out_ready   = 1'b0;
    w_flush     = 1'b0;
    w_in_valid  = 1'b0;
    w_in_data   = 64'h0;
    w_in_offset = 3'd0;
    w_in_size   = 2'd0;
    w_in_sign   = 1'b0;
    w_in_tag    = 5'd0;
    w_out_ready = 1'b0;
    test_reset();
    test_extend32();
    test_extend64();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
